// File: rtl/smart_house_pkg.sv
// rtl/smart_house_pkg.sv - shared types and ASCII constants for the smart-house command path
// Contents: char_t, rx_state_t, ASCII case constants, fold_case() helper.
package smart_house_pkg;

  typedef logic [7:0] char_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam char_t ASCII_UPPER_A = 8'h41;
  localparam char_t ASCII_UPPER_Z = 8'h5A;
  localparam char_t CASE_OFFSET   = 8'h20;

  // Maps 'A'..'Z' onto 'a'..'z'; every other byte passes unchanged.
  function automatic char_t fold_case(input char_t c);
    if (c >= ASCII_UPPER_A && c <= ASCII_UPPER_Z) begin
      return c + CASE_OFFSET;
    end
    return c;
  endfunction

endpackage

// File: rtl/smart_house_char_fifo.sv
// rtl/smart_house_char_fifo.sv - first-word-fall-through character FIFO
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   push, push_data   : write request and character
//   pop               : read request (ignored when empty)
//   head_data         : oldest entry, forced to 0 while empty
//   empty, full, level: occupancy status
module smart_house_char_fifo
  import smart_house_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  char_t                       push_data,
  input  logic                        pop,
  output char_t                       head_data,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  char_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(FIFO_DEPTH));

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  // When full, wr_ptr equals rd_ptr: the head is read before the edge and
  // overwritten on it, which leaves the new byte as the last entry.
  assign w_do_pop  = pop & ~w_empty;
  assign w_do_push = push & (~w_full | w_do_pop);

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Gated so stale memory never shows while empty (including after reset).
  assign head_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign empty     = w_empty;
  assign full      = w_full;
  assign level     = r_level;

endmodule

// File: rtl/smart_house_uart_rx.sv
// rtl/smart_house_uart_rx.sv - 8N1 UART receiver with case folding feeding a character FIFO
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   rx_serial    : asynchronous UART line, idles high
//   char_data    : head-of-FIFO character (0 while char_valid = 0)
//   char_valid   : FIFO non-empty
//   char_ready   : consumer accepts head when char_valid & char_ready
//   frame_err    : one-cycle pulse, stop bit sampled low
//   overflow     : one-cycle pulse, byte dropped because FIFO full
//   fifo_level   : number of stored characters
module smart_house_uart_rx
  import smart_house_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int FOLD_CASE    = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rx_serial,
  output char_t                       char_data,
  output logic                        char_valid,
  input  logic                        char_ready,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int             CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  rx_state_t     r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  char_t         r_shift;
  logic          r_frame_err;
  logic          r_overflow;

  rx_state_t     w_state_nxt;
  logic [CW-1:0] w_clk_cnt_nxt;
  logic [2:0]    w_bit_cnt_nxt;
  char_t         w_shift_nxt;
  logic          w_push;
  logic          w_frame_err_nxt;
  char_t         w_push_data;
  logic          w_line;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;

  assign w_line = r_sync2;

  always_comb begin
    w_state_nxt     = r_state;
    w_clk_cnt_nxt   = r_clk_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_push          = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_clk_cnt_nxt = '0;
        if (!w_line) begin
          w_state_nxt   = START;
          w_bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (r_clk_cnt == C_HALF_LAST) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = w_line ? IDLE : DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (r_clk_cnt == C_BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          w_shift_nxt   = {w_line, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = STOP;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (r_clk_cnt == C_BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          if (w_line) begin
            w_push      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = WAIT_HIGH;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // Holding here keeps a break (line stuck low) from looking like a new start bit.
        w_clk_cnt_nxt = '0;
        if (w_line) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_clk_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_sync1     <= rx_serial;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overflow  <= w_push & w_full & ~w_pop;
    end
  end

  assign w_push_data = (FOLD_CASE != 0) ? fold_case(r_shift) : r_shift;
  assign w_pop       = ~w_empty & char_ready;

  smart_house_char_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (w_push),
    .push_data(w_push_data),
    .pop      (w_pop),
    .head_data(char_data),
    .empty    (w_empty),
    .full     (w_full),
    .level    (fifo_level)
  );

  assign char_valid = ~w_empty;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_smart_house_uart_rx.sv
// tb/tb_smart_house_uart_rx.sv - directed self-checking bench for smart_house_uart_rx
module tb_smart_house_uart_rx;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_serial;
  logic       char_ready;
  logic [7:0] char_data;
  logic       char_valid;
  logic       frame_err;
  logic       overflow;
  logic [2:0] fifo_level;
  logic [7:0] nf_char_data;
  logic       nf_char_valid;
  logic       nf_frame_err;
  logic       nf_overflow;
  logic [2:0] nf_fifo_level;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] rx_q[$];

  always #5 clock = ~clock;

  smart_house_uart_rx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4), .FOLD_CASE(1)) dut (
    .clock(clock), .reset(reset), .rx_serial(rx_serial),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .frame_err(frame_err), .overflow(overflow), .fifo_level(fifo_level)
  );

  smart_house_uart_rx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4), .FOLD_CASE(0)) dut_nf (
    .clock(clock), .reset(reset), .rx_serial(rx_serial),
    .char_data(nf_char_data), .char_valid(nf_char_valid), .char_ready(char_ready),
    .frame_err(nf_frame_err), .overflow(nf_overflow), .fifo_level(nf_fifo_level)
  );

  always @(posedge clock) cyc <= cyc + 1;

  always begin
    @(negedge clock);
    #1;
    if (char_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = char_valid;
    if (frame_err) fe_cnt++;
    if (overflow) ov_cnt++;
    if (char_valid && char_ready) rx_q.push_back(char_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_serial = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (16) @(negedge clock);
    end
    rx_serial = stop_bit;
    repeat (16) @(negedge clock);
    rx_serial = 1'b1;
  endtask

  initial begin
    int t0;
    int fe0;
    int ov0;
    logic [7:0] ow_tx [10];
    logic [7:0] ow_exp [10];
    logic [7:0] pb;

    ow_tx  = '{8'h4F, 8'h70, 8'h65, 8'h6E, 8'h57, 8'h69, 8'h6E, 8'h64, 8'h6F, 8'h77};
    ow_exp = '{8'h6F, 8'h70, 8'h65, 8'h6E, 8'h77, 8'h69, 8'h6E, 8'h64, 8'h6F, 8'h77};

    reset = 1'b0;
    rx_serial = 1'b1;
    char_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_char_data", char_data, 8'h00);
    check("reset_char_valid", char_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_fifo_level", fifo_level, 3'd0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // 'O' with no consumer: latency, folding, level
    t0 = cyc;
    send_byte(8'h4F, 1'b1);
    repeat (2) @(negedge clock);
    check("latency_155", rise_cyc - t0, 155);
    check("fold_O", char_data, 8'h6F);
    check("nofold_O", nf_char_data, 8'h4F);
    check("level_after_O", fifo_level, 3'd1);
    char_ready = 1'b1;
    @(negedge clock);
    char_ready = 1'b0;
    @(negedge clock);
    check("level_after_pop", fifo_level, 3'd0);

    // "OpenWindow" back-to-back, consumer always ready
    rx_q.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    char_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(ow_tx[i], 1'b1);
    repeat (20) @(negedge clock);
    check("ow_count", rx_q.size(), 10);
    for (int i = 0; i < 10; i++) check($sformatf("ow_char%0d", i), rx_q[i], ow_exp[i]);
    check("ow_frame_err", fe_cnt - fe0, 0);
    check("ow_overflow", ov_cnt - ov0, 0);

    // Five bytes into a depth-4 FIFO
    char_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i), 1'b1);
    repeat (10) @(negedge clock);
    check("ovf_level", fifo_level, 3'd4);
    check("ovf_pulses", ov_cnt - ov0, 1);
    rx_q.delete();
    char_ready = 1'b1;
    repeat (6) @(negedge clock);
    char_ready = 1'b0;
    check("ovf_pop_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovf_pop%0d", i), rx_q[i], 8'h31 + 8'(i));

    // Short low glitch, then a framing error followed by a held-low line
    fe0 = fe_cnt;
    rx_serial = 1'b0;
    repeat (6) @(negedge clock);
    rx_serial = 1'b1;
    repeat (30) @(negedge clock);
    check("glitch_level", fifo_level, 3'd0);
    check("glitch_valid", char_valid, 1'b0);
    check("glitch_frame_err", fe_cnt - fe0, 0);
    send_byte(8'hA5, 1'b0);
    rx_serial = 1'b0;
    repeat (40) @(negedge clock);
    rx_serial = 1'b1;
    repeat (200) @(negedge clock);
    check("ferr_pulses", fe_cnt - fe0, 1);
    check("ferr_level", fifo_level, 3'd0);

    // Reset in the middle of bit 4 with two entries buffered
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    repeat (2) @(negedge clock);
    check("pre_reset_level", fifo_level, 3'd2);
    check("pre_reset_head", char_data, 8'h61);
    pb = 8'h55;
    rx_serial = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx_serial = pb[i];
      repeat (16) @(negedge clock);
    end
    rx_serial = pb[4];
    repeat (8) @(negedge clock);
    reset = 1'b0;
    rx_serial = 1'b1;
    #1;
    check("mid_reset_char_data", char_data, 8'h00);
    check("mid_reset_char_valid", char_valid, 1'b0);
    check("mid_reset_fifo_level", fifo_level, 3'd0);
    check("mid_reset_frame_err", frame_err, 1'b0);
    check("mid_reset_overflow", overflow, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    send_byte(8'h61, 1'b1);
    repeat (2) @(negedge clock);
    check("post_reset_char", char_data, 8'h61);
    check("post_reset_level", fifo_level, 3'd1);

    // Full FIFO; the stop-bit push lands on the same edge as a pop
    char_ready = 1'b1;
    @(negedge clock);
    char_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), 1'b1);
    repeat (2) @(negedge clock);
    check("full_level", fifo_level, 3'd4);
    rx_q.delete();
    ov0 = ov_cnt;
    fork
      send_byte(8'h39, 1'b1);
      begin
        repeat (154) @(negedge clock);
        char_ready = 1'b1;
        @(negedge clock);
        char_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clock);
    check("simul_overflow", ov_cnt - ov0, 0);
    check("simul_level", fifo_level, 3'd4);
    char_ready = 1'b1;
    repeat (6) @(negedge clock);
    char_ready = 1'b0;
    check("simul_count", rx_q.size(), 5);
    for (int i = 0; i < 4; i++) check($sformatf("simul_pop%0d", i), rx_q[i], 8'h31 + 8'(i));
    check("simul_last", rx_q[4], 8'h39);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/smart_house_uart_rx.md
# smart_house_uart_rx

Serial command receiver for the smart-house controller: it deserialises an 8N1 UART line from the wall panel into ASCII characters, folds upper case to lower case, and buffers them in a small FIFO. It sits directly upstream of the house control FSM and feeds that FSM's character input, one byte per accepted handshake. The control FSM matches the lowercase sequence "openwindow" on this stream.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; must be even and ≥ 8.
- FIFO_DEPTH, 4: character buffer entries; must be a power of two.
- FOLD_CASE, 1: when 1, bytes 0x41–0x5A are stored as byte + 0x20.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  **asynchronous, active-low reset**.
- rx_serial  in  1  UART line; idles high; asynchronous to clock.
- char_data  out  8  head-of-FIFO character; valid only while char_valid = 1.
- char_valid  out  1  FIFO non-empty.
- char_ready  in  1  consumer accepts the head when char_valid & char_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overflow  out  1  one-cycle pulse: received byte dropped because FIFO full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of stored characters.

## Operation
- rx_serial passes through a 2-flop synchroniser (reset value 1); every reference to "line" below means the synchronised value.
- Receiver FSM states:
  - IDLE: line low → START, bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. Low → DATA. High → IDLE (glitch rejected, nothing reported).
  - DATA: every CLKS_PER_BIT cycles sample one bit into the shift register, LSB first. After bit 7 → STOP.
  - STOP: wait CLKS_PER_BIT cycles, then sample. High → push the byte and go to IDLE. Low → frame_err pulse, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until line is high, then go to IDLE. This prevents a break condition from retriggering reception.
- Case folding is applied at push time; all other byte values pass unchanged.
- FIFO behaviour:
  - First-word-fall-through: char_data shows the oldest entry.
  - A pop happens when char_valid & char_ready.
  - Push into a full FIFO with no pop in the same cycle: the byte is dropped, overflow pulses, and contents are unchanged.
  - Push and pop in the same cycle, full or not: both take effect and fifo_level is unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level saturates by construction (0..FIFO_DEPTH).
- Reset, asserted at any time including mid-character:
  - FSM goes to IDLE, the FIFO empties, and pointers clear.
  - The partial byte is lost.
  - All outputs read 0 (char_data = 8'h00, char_valid = 0, frame_err = 0, overflow = 0, fifo_level = 0).

## Timing
- Synchroniser latency: 2 cycles.
- The stop-bit sample and the FIFO write occur on the same edge. char_valid rises on the next edge (1 cycle after the stop sample).
- Start falling edge on the pin to char_valid high: 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles. For CLKS_PER_BIT = 16 this is 155 cycles.
- frame_err and overflow are registered, exactly 1 cycle wide, asserted the cycle after the stop sample.
- char_data updates the cycle after a pop. It is combinationally independent of char_ready.
- Back-to-back characters with no idle gap are supported. The STOP → IDLE → START path loses no cycles beyond the nominal half-bit alignment.

## Structure
- smart_house_pkg holds:
  - typedef char_t (8-bit).
  - Enum rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}.
  - ASCII constants: ASCII_UPPER_A = 8'h41, ASCII_UPPER_Z = 8'h5A, CASE_OFFSET = 8'h20.
  - Shared by the control FSM for its "openwindow" comparisons.
- One sub-module, smart_house_char_fifo:
  - Parameterised by FIFO_DEPTH.
  - Ports: push, push_data, pop, head_data, empty, full, level.
  - Holds all FIFO boundary logic.
- The top level holds the synchroniser, the bit/baud counters and the receiver FSM.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and FIFO_DEPTH = 4.
- Send 'O' (0x4F) with char_ready = 0 → char_valid rises 155 cycles after the start edge, char_data = 0x6F, fifo_level = 1. With FOLD_CASE = 0 → char_data = 0x4F.
- Send "openwindow" back-to-back with char_ready = 1 → the consumer sees exactly 0x6F 0x70 0x65 0x6E 0x77 0x69 0x6E 0x64 0x6F 0x77 in order, with no frame_err or overflow.
- Send 5 bytes 0x31–0x35 with char_ready = 0 → fifo_level = 4 and one overflow pulse after byte 5. Popping then yields 0x31–0x34.
- Low glitch of 6 cycles on rx_serial → no byte, no frame_err, FSM back in IDLE. Then send a byte with stop bit forced low and line held low for 40 cycles → one frame_err pulse, no push, no further reception until the line goes high.
- Assert reset during bit 4 of a byte while the FIFO holds 2 entries → all outputs 0 immediately. A following valid byte 0x61 is received correctly with fifo_level = 1.
- FIFO full; stop-bit push coincides with char_ready = 1 → no overflow, fifo_level stays 4, and the new byte appears as the last entry.
